// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared types and defaults for the data-memory responder.
package dmem_responder_pkg;
  typedef logic [31:0] rv32i_word;
  typedef logic [3:0] rv32i_mem_wmask;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam int unsigned DMEM_DEFAULT_LATENCY = 2;
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: word-addressed RAM with per-byte write enables and an asynchronous read port.
module dmem_bank
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  rv32i_word             wdata,
  output rv32i_word             rdata
);
  rv32i_word mem [2**ADDR_WIDTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder with request latch, error checks and a byte-lane RAM.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = DMEM_DEFAULT_LATENCY
) (
  input  logic           clk,
  input  logic           rst_n,
  input  rv32i_word      dmem_address,
  input  logic           dmem_read,
  input  logic           dmem_write,
  input  rv32i_mem_wmask dmem_byte_enable,
  input  rv32i_word      dmem_wdata,
  output rv32i_word      dmem_rdata,
  output logic           dmem_resp,
  output logic           dmem_err,
  output logic           busy
);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  dmem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  rv32i_word addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  rv32i_mem_wmask be_q, be_d;
  logic read_q, read_d, write_q, write_d;
  logic resp_q, resp_d, err_q, err_d, busy_q, busy_d;
  logic idle, accept, enter_resp, cur_read, cur_write, cur_err;
  rv32i_word cur_addr, cur_wdata, bank_rdata;
  rv32i_mem_wmask cur_be;
  logic [3:0] bank_we;
  // With LATENCY=1 the RESP edge is the accept edge, so commit/read use the live inputs while idle.
  always_comb begin
    idle       = state_q == IDLE;
    accept     = idle && (dmem_read || dmem_write);
    cur_addr   = idle ? dmem_address : addr_q;
    cur_read   = idle ? dmem_read : read_q;
    cur_write  = idle ? dmem_write : write_q;
    cur_be     = idle ? dmem_byte_enable : be_q;
    cur_wdata  = idle ? dmem_wdata : wdata_q;
    cur_err    = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (ADDR_WIDTH + 2)) != '0) ||
                 (cur_read && cur_write);
    enter_resp = (accept && LATENCY == 1) || (state_q == WAIT && cnt_q == 4'd1);
    state_d    = enter_resp ? RESP : (accept || state_q == WAIT) ? WAIT : IDLE;
    cnt_d      = accept ? LAT_M1 : (state_q == WAIT) ? cnt_q - 4'd1 : 4'd0;
    addr_d     = accept ? dmem_address : addr_q;
    read_d     = accept ? dmem_read : read_q;
    write_d    = accept ? dmem_write : write_q;
    be_d       = accept ? dmem_byte_enable : be_q;
    wdata_d    = accept ? dmem_wdata : wdata_q;
    resp_d     = enter_resp;
    err_d      = enter_resp && cur_err;
    rdata_d    = (enter_resp && cur_read && !cur_err) ? bank_rdata : '0;
    busy_d     = state_d != IDLE;
    bank_we    = (enter_resp && cur_write && !cur_err && rst_n) ? cur_be : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end
  dmem_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .addr (cur_addr[ADDR_WIDTH+1:2]),
    .wdata(cur_wdata),
    .rdata(bank_rdata)
  );
  assign dmem_rdata = rdata_q;
  assign dmem_resp  = resp_q;
  assign dmem_err   = err_q;
  assign busy       = busy_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the pipeline's data-memory port. It consumes the dmem_read / dmem_write / dmem_byte_enable requests that the datapath control word drives, and answers them with dmem_resp and dmem_rdata after a fixed, parameterised latency. It holds a word-addressed, byte-lane-writable RAM. The bench and FPGA top use it in place of the cache hierarchy for pipeline bring-up.

Parameters:
- ADDR_WIDTH, 10: word-address bits; depth = 2**ADDR_WIDTH words; valid byte range 0 .. 4*2**ADDR_WIDTH-4.
- LATENCY, 2: cycles from request-accept edge to dmem_resp cycle; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- dmem_address  in  32  byte address, rv32i_word.
- dmem_read  in  1  read request level.
- dmem_write  in  1  write request level.
- dmem_byte_enable  in  4  write lane mask (rv32i_mem_wmask); bit i enables byte i = wdata[8i+7:8i].
- dmem_wdata  in  32  write data.
- dmem_rdata  out  32  read data, valid only while dmem_resp=1.
- dmem_resp  out  1  single-cycle completion pulse.
- dmem_err  out  1  error flag, valid only while dmem_resp=1.
- busy  out  1  high from the accept edge until the end of the RESP cycle.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE.
  - dmem_resp=0, dmem_err=0, dmem_rdata=0, busy=0.
  - counter=0; latched request cleared.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if read|write is high at an edge, latch address, read, write, byte_enable and wdata, and load counter=LATENCY-1. Go to RESP if LATENCY==1, else go to WAIT.
  - WAIT: decrement the counter each edge; go to RESP on the edge where the counter reaches 0.
  - RESP: lasts exactly one cycle, then returns to IDLE. The request is never re-accepted directly from RESP.
- Latency: if a request is first sampled at edge t, dmem_resp is high in the cycle after edge t+LATENCY-1. That is, with a request held from cycle c, resp appears in cycle c+LATENCY.
- Latched copy: inputs are ignored outside IDLE; changes in WAIT/RESP have no effect.
- Error detection, on the latched request. err=1 if any of:
  - addr[1:0] != 0;
  - addr[31:ADDR_WIDTH+2] != 0;
  - read and write both high.
- On error: no RAM write, rdata=0, err=1. Timing is identical to a good request.
- Write, good request:
  - RAM commits on the edge entering RESP.
  - Only lanes with byte_enable=1 are written; byte_enable=0000 still produces resp with no change.
  - rdata=0 during a write RESP.
- Read, good request:
  - rdata is registered on the edge entering RESP from RAM[addr[ADDR_WIDTH+1:2]].
  - Full word returned; byte_enable is ignored.
  - Read-after-write across requests returns the new data.
- Back-to-back: a requester holding read or write high through RESP creates a new request accepted at the first IDLE edge. The second resp comes LATENCY+1 cycles after the first.
- Reset mid-operation (WAIT or RESP): the pending write is dropped if reset arrives before the commit edge, and no resp is issued.
- Outputs are registered; there is no combinational input-to-output path.

Decomposition:
- rv32i_types package:
  - reuse rv32i_word and rv32i_mem_wmask;
  - add dmem_state_t enum {IDLE, WAIT, RESP};
  - add constant DMEM_DEFAULT_LATENCY=2.
- Sub-module dmem_bank:
  - 2**ADDR_WIDTH x 32 array;
  - four per-byte write enables;
  - asynchronous read port;
  - no reset.
- The FSM, counter, latch and error logic stay in dmem_responder.

Test Plan:
1. LATENCY=2. Write 0x10, wdata 0xDEADBEEF, be 1111, held from cycle c → resp=1 in cycle c+2 only, err=0. Then read 0x10 → rdata 0xDEADBEEF.
2. Write 0x10, be 0100, wdata 0x00AA0000 → a following read of 0x10 returns 0xDEAABEEF. Write with be 0000 → the word is unchanged and resp still fires.
3. Read 0x12 (misaligned) and write 0x1000 with ADDR_WIDTH=10 → each gets resp at latency with err=1 and rdata=0. Word 0 and 0x10 are unchanged on readback.
4. Read and write both high at 0x10 → err=1, no write; a readback returns the prior value.
5. Read 0x10 held high continuously with LATENCY=1 → resp in cycles c+1, c+3, c+5, and so on. Changing the address during RESP does not alter the current rdata.
6. Write 0x20, 0x12345678; drive rst_n=0 in the WAIT cycle → no resp, busy=0. After reset, reading 0x20 returns the pre-write contents. Repeat with LATENCY=1 to check the IDLE→RESP path.
